// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MEIE_BIT     = 11;
  localparam int unsigned MEIP_BIT     = 11;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_ECALL   = 4'd11;
  localparam logic [3:0] IRQ_MEXT    = 4'd11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } trap_state_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access port between the decode/execute stage and the CSR file.
interface csr_trap_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_en;
  logic [1:0]      csr_op;
  logic            csr_inm;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_data;
  logic [4:0]      src_idx;
  logic [XLEN-1:0] rd_data;
  logic            illegal;

  modport master (
    output csr_en, csr_op, csr_inm, csr_addr, rs1_data, src_idx,
    input  rd_data, illegal
  );

  modport slave (
    input  csr_en, csr_op, csr_inm, csr_addr, rs1_data, src_idx,
    output rd_data, illegal
  );
endinterface

// File: rtl/csr_trap_unit_counter.sv
// Free-running counter with increment enable and half-word write ports;
// a write to either half suppresses the increment for the whole counter.
module csr_counter #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned HALF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wdata,
  output logic [CNT_W-1:0]  count
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = count;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_nxt[HALF_W-1:0] = wdata;
      if (wr_hi && (CNT_W > HALF_W)) cnt_nxt[CNT_W-1 -: HALF_W] = wdata;
    end else if (inc) begin
      cnt_nxt = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= cnt_nxt;
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with Zicsr read-modify-write, trap entry, mret and
// 64-bit cycle/instret counters; drives the PC redirect for traps and returns.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  csr_trap_unit_if.slave     csr,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [PC_W-1:0]    pc_cur,
  input  logic               irq_ext,
  input  logic               mret,
  input  logic               instr_ret,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc
);

  localparam bit HAS_HI = (CNT_W > XLEN);

  trap_state_e     state;
  logic            mie_bit, mpie_bit, meie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  logic [XLEN-1:0] cur_val, operand, wval, trap_base, trap_pc, pc_ext;
  logic            implemented, wr_attempt, irq_take, take_trap, csr_commit;

  assign pc_ext = {{(XLEN-PC_W){1'b0}}, pc_cur};

  always_comb begin
    cur_val     = '0;
    implemented = 1'b1;
    unique case (csr.csr_addr)
      CSR_MSTATUS: begin
        cur_val[MSTATUS_MIE]  = mie_bit;
        cur_val[MSTATUS_MPIE] = mpie_bit;
      end
      CSR_MIE:      cur_val[MEIE_BIT] = meie;
      CSR_MTVEC:    cur_val = mtvec;
      CSR_MSCRATCH: cur_val = mscratch;
      CSR_MEPC:     cur_val = mepc;
      CSR_MCAUSE:   cur_val = mcause;
      CSR_MTVAL:    cur_val = mtval;
      CSR_MIP:      cur_val[MEIP_BIT] = irq_ext;
      CSR_MCYCLE, CSR_CYCLE:     cur_val = cycle_cnt[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: cur_val = instret_cnt[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH: begin
        if (HAS_HI) cur_val = cycle_cnt[CNT_W-1 -: XLEN];
        else        implemented = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (HAS_HI) cur_val = instret_cnt[CNT_W-1 -: XLEN];
        else        implemented = 1'b0;
      end
      default: implemented = 1'b0;
    endcase
  end

  always_comb begin
    operand = csr.csr_inm ? {{(XLEN-5){1'b0}}, csr.src_idx} : csr.rs1_data;
    unique case (csr.csr_op)
      CSR_RS:  wval = cur_val | operand;
      CSR_RC:  wval = cur_val & ~operand;
      default: wval = operand;
    endcase
  end

  assign wr_attempt  = csr.csr_en &&
                       ((csr.csr_op == CSR_RW) ||
                        (((csr.csr_op == CSR_RS) || (csr.csr_op == CSR_RC)) && (csr.src_idx != 5'd0)));
  assign csr.illegal = csr.csr_en && (!implemented || ((csr.csr_addr[11:10] == 2'b11) && wr_attempt));
  assign csr.rd_data = csr.csr_en ? cur_val : '0;

  // Priority: exception > interrupt > mret > CSR write; nothing is accepted in REDIR.
  assign irq_take   = irq_ext && mie_bit && meie;
  assign take_trap  = exc_valid || irq_take;
  assign csr_commit = (state == ST_RUN) && wr_attempt && !csr.illegal && !take_trap && !mret;

  always_comb begin
    trap_base = {mtvec[XLEN-1:2], 2'b00};
    trap_pc   = (mtvec[0] && !exc_valid) ? trap_base + XLEN'(4 * 11) : trap_base;
  end

  csr_counter #(.CNT_W(CNT_W), .HALF_W(XLEN)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_commit && (csr.csr_addr == CSR_MCYCLE)),
    .wr_hi (HAS_HI && csr_commit && (csr.csr_addr == CSR_MCYCLEH)),
    .wdata (wval),
    .count (cycle_cnt)
  );

  csr_counter #(.CNT_W(CNT_W), .HALF_W(XLEN)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_ret),
    .wr_lo (csr_commit && (csr.csr_addr == CSR_MINSTRET)),
    .wr_hi (HAS_HI && csr_commit && (csr.csr_addr == CSR_MINSTRETH)),
    .wdata (wval),
    .count (instret_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mie_bit        <= 1'b0;
      mpie_bit       <= 1'b0;
      meie           <= 1'b0;
      mtvec          <= XLEN'(MTVEC_RST);
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
    end else begin
      state          <= ST_RUN;
      redirect_valid <= 1'b0;
      if (state == ST_RUN) begin
        if (take_trap) begin
          mepc           <= {pc_ext[XLEN-1:2], 2'b00};
          mcause         <= exc_valid ? {{(XLEN-4){1'b0}}, exc_cause}
                                      : {1'b1, {(XLEN-5){1'b0}}, IRQ_MEXT};
          mtval          <= exc_valid ? exc_tval : '0;
          mpie_bit       <= mie_bit;
          mie_bit        <= 1'b0;
          state          <= ST_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_pc[PC_W-1:0];
        end else if (mret) begin
          mie_bit        <= mpie_bit;
          mpie_bit       <= 1'b1;
          state          <= ST_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc[PC_W-1:0];
        end else if (csr_commit) begin
          unique case (csr.csr_addr)
            CSR_MSTATUS: begin
              mie_bit  <= wval[MSTATUS_MIE];
              mpie_bit <= wval[MSTATUS_MPIE];
            end
            CSR_MIE:      meie     <= wval[MEIE_BIT];
            CSR_MTVEC:    mtvec    <= {wval[XLEN-1:2], 1'b0, wval[0]};
            CSR_MSCRATCH: mscratch <= wval;
            CSR_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause   <= wval;
            CSR_MTVAL:    mtval    <= wval;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the rv32i core. Generalises the single-CSR write/read path in the data path.
- Implements Zicsr read-modify-write ops, exception and external-interrupt entry, `mret`, and 64-bit cycle/instret counters.
- Supports direct and vectored `mtvec` modes.
- Sits beside the register file: `rd_data` feeds the result mux, and `redirect_*` feeds the PC mux.

Parameters:
- XLEN, 32, CSR/data width
- PC_W, 16, program counter width; PC is zero-extended to XLEN in CSRs
- CNT_W, 64, counter width (32 or 64; upper-half CSRs exist only when 64)
- MTVEC_RST, 32'h0000_0100, reset value of mtvec

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  funct3[1:0]: 01 RW, 10 RS, 11 RC, 00 none
- csr_inm  in  1  operand is zero-extended uimm (1) or rs1_data (0)
- csr_addr  in  12  CSR address
- rs1_data  in  XLEN  register operand
- src_idx  in  5  rs1 index or uimm field
- rd_data  out  XLEN  old CSR value (combinational)
- illegal  out  1  illegal CSR access (combinational)
- exc_valid  in  1  synchronous exception
- exc_cause  in  4  exception code
- exc_tval  in  XLEN  faulting value
- pc_cur  in  PC_W  PC of current instruction
- irq_ext  in  1  external interrupt level
- mret  in  1  mret executing
- instr_ret  in  1  instruction retired
- redirect_valid  out  1  PC redirect pulse
- redirect_pc  out  PC_W  redirect target

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
  - mie 0x304: MEIE bit11 only.
  - mtvec 0x305: bit1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only, MEIP bit11 = irq_ext.
  - mcycle 0xB00, minstret 0xB02.
  - mcycleh 0xB80, minstreth 0xB82: only when CNT_W=64.
  - cycle/instret/cycleh/instreth 0xC00/0xC02/0xC80/0xC82: read-only shadows.
- Read: rd_data = current value, combinational, whenever csr_en. Unimplemented address → rd_data=0.
- Write intent:
  - Write is attempted when csr_op=RW, or when csr_op=RS/RC with src_idx≠0.
  - Operand = csr_inm ? {27'b0,src_idx} : rs1_data.
  - New value: RW operand; RS old|operand; RC old&~operand. Committed at the clk edge.
- illegal=1 when csr_en and either:
  - the address is unimplemented, or
  - the address[11:10]=2'b11 and a write is attempted.
  - When illegal is set, no CSR changes. The core returns it as exc_cause=2.
- FSM, two states:
  - RUN: accepts events.
  - REDIR: one cycle, redirect_valid=1. exc_valid/irq_ext/mret/csr writes are ignored (pipeline flushing). Next state is RUN.
- Event priority in RUN (highest first): exc_valid > interrupt > mret > CSR write. Only the winner takes effect; a lower-priority CSR write in the same cycle is dropped.
- Interrupt is taken when irq_ext & MIE & MEIE.
- Trap entry (exception or interrupt):
  - mepc ← pc_cur.
  - mcause ← {int, 0…, code}: exception {0, exc_cause}; interrupt {1, 11}.
  - mtval ← exc_tval for exceptions, 0 for interrupts.
  - MPIE ← MIE; MIE ← 0.
  - Next state REDIR.
  - redirect_pc = mtvec base (mtvec[XLEN-1:2]<<2) in all cases, except mtvec[0]=1 with an interrupt: base + 4*11.
- mret: MIE ← MPIE; MPIE ← 1; redirect_pc ← mepc; next state REDIR.
- Counters:
  - mcycle increments every cycle; minstret increments when instr_ret.
  - A same-cycle CSR write to either half wins over the increment for the whole counter that cycle.
  - Both wrap to 0 at all-ones.
  - Counters keep running in REDIR.
- Reset (rst high at a clk edge): all CSRs 0 except mtvec=MTVEC_RST. State RUN, redirect_valid=0, redirect_pc=0. Reset overrides all events, including a trap in flight during REDIR.

Decomposition:
- Shared package csr_pkg:
  - CSR address constants.
  - csr_op encodings.
  - mstatus bit indices (MIE=3, MPIE=7) and MEIE/MEIP=11.
  - Exception codes: illegal=2, ecall=11; interrupt code 11.
  - FSM state typedef.
- One natural sub-module: csr_counter (CNT_W-wide counter with increment enable and per-half write ports), instantiated twice.

Test Plan:
- rst; csrrw x0 with 0x305 ← 0x200 → next cycle mtvec reads 0x200; rd_data showed 0x100 during the write.
- csrrsi 0x340 uimm=5, then csrrci uimm=1 → mscratch 5 then 4. csrrs with src_idx=0 on 0xC00 → illegal=0, no change.
- exc_valid cause=2, pc_cur=0x0040, tval=0x00551073 → next cycle:
  - redirect_valid=1, redirect_pc=0x200.
  - mepc=0x40, mcause=2, mtval=0x00551073.
- MIE=1, MEEIE=1, mtvec=0x201, irq_ext=1, pc_cur=0x80 → redirect_pc=0x22C, mcause=0x8000000B, MIE=0, MPIE=1. Follow with mret → redirect_pc=0x80, MIE=1.
- csrrw 0xC00 → illegal=1, no write. Write 0xFFFFFFFF to 0xB00 and 0xB80 → mcycle wraps to 0 on the following cycle.
- exc_valid and a csrrw to 0x340 in the same cycle → only the trap takes effect. exc_valid during REDIR → ignored. rst during REDIR → redirect_valid=0 next cycle.
